branch_predictor_pht: RTL and testbench

BRANCH_PREDICTOR_PHT -- requirements
Module: branch_predictor_pht

---
 rtl/branch_predictor_pht.sv | 110 +++++++++++
 tb/tb_branch_predictor_pht.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_pht.sv
// Pattern history table of saturating counters, indexed by the fetch PC.
// Defining GSHARE_EN XORs a global history register into the index (gshare).
module branch_predictor_pht #(
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2,
    parameter int GHR_BITS   = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           PCF,
    output logic                  PredictTakenF,
    output logic [INDEX_BITS-1:0] PredictIndexF,
    input  logic                  UpdateE,
    input  logic [INDEX_BITS-1:0] UpdateIndexE,
    input  logic                  BranchTakenE,
    input  logic                  PredictedTakenE,
    output logic                  MispredictE,
    output logic [15:0]           MispredictCount
);

    localparam int DEPTH = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [CTR_BITS-1:0]   ctr_q [DEPTH];
    logic [CTR_BITS-1:0]   ctr_cur;
    logic [CTR_BITS-1:0]   ctr_d;
    logic [INDEX_BITS-1:0] pc_idx;
    logic [INDEX_BITS-1:0] fetch_idx;
    logic [15:0]           cnt_q;
    logic [15:0]           cnt_d;
    logic                  unused_pcf_bits;

    // PCs are word aligned, so the byte offset and the upper bits never index.
    assign pc_idx          = PCF[INDEX_BITS+1:2];
    assign unused_pcf_bits = ^{PCF[31:INDEX_BITS+2], PCF[1:0]};

`ifdef GSHARE_EN
    logic [GHR_BITS-1:0] ghr_q;
    logic [GHR_BITS-1:0] ghr_d;

    always_comb begin
        ghr_d = ghr_q;
        if (UpdateE) begin
            ghr_d = GHR_BITS'({ghr_q, BranchTakenE});
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign fetch_idx = pc_idx ^ INDEX_BITS'(ghr_q);
`else
    assign fetch_idx = pc_idx;
`endif

    // Prediction reads the stored counter directly: a same-cycle update is not bypassed.
    assign PredictIndexF = fetch_idx;
    assign PredictTakenF = ctr_q[fetch_idx][CTR_BITS-1];

    assign ctr_cur = ctr_q[UpdateIndexE];

    always_comb begin
        ctr_d = ctr_cur;
        if (BranchTakenE) begin
            if (ctr_cur != CTR_MAX) begin
                ctr_d = ctr_cur + 1'b1;
            end
        end else begin
            if (ctr_cur != '0) begin
                ctr_d = ctr_cur - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= '0;
            end
        end else if (UpdateE) begin
            ctr_q[UpdateIndexE] <= ctr_d;
        end
    end

    assign MispredictE = UpdateE & (BranchTakenE ^ PredictedTakenE);

    always_comb begin
        cnt_d = cnt_q;
        if (MispredictE && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign MispredictCount = cnt_q;

endmodule

// File: tb/tb_branch_predictor_pht.sv
// Self-checking bench for branch_predictor_pht at default parameters.
// Build with +define+GSHARE_EN to exercise the gshare indexing mode.
module tb_branch_predictor_pht;

  logic        clk;
  logic        reset;
  logic [31:0] PCF;
  logic        PredictTakenF;
  logic [5:0]  PredictIndexF;
  logic        UpdateE;
  logic [5:0]  UpdateIndexE;
  logic        BranchTakenE;
  logic        PredictedTakenE;
  logic        MispredictE;
  logic [15:0] MispredictCount;

  branch_predictor_pht dut (
    .clk             (clk),
    .reset           (reset),
    .PCF             (PCF),
    .PredictTakenF   (PredictTakenF),
    .PredictIndexF   (PredictIndexF),
    .UpdateE         (UpdateE),
    .UpdateIndexE    (UpdateIndexE),
    .BranchTakenE    (BranchTakenE),
    .PredictedTakenE (PredictedTakenE),
    .MispredictE     (MispredictE),
    .MispredictCount (MispredictCount)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model
  logic [1:0]  m_ctr [64];
  logic [15:0] m_cnt;
  logic [5:0]  m_ghr;

  // scoreboard: {index, taken, mispredict, count}
  logic [23:0] exp_q[$];

  typedef struct {
    logic [31:0] pc;
    logic        upd;
    logic [5:0]  uidx;
    logic        bt;
    logic        pt;
    logic        exp_pred;
    logic        exp_misp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] hist_term();
`ifdef GSHARE_EN
    return m_ghr;
`else
    return 6'd0;
`endif
  endfunction

  // PC that fetches table entry idx given the current model history
  function automatic logic [31:0] pc_for(input logic [5:0] idx);
    logic [5:0] raw;
    raw = idx ^ hist_term();
    return {24'd0, raw, 2'b00};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_ctr[i] = 2'd0;
    m_cnt = 16'd0;
    m_ghr = 6'd0;
  endtask

  // driver: one clock cycle of stimulus, outputs checked mid-cycle
  task automatic cycle(input logic [31:0] pc, input logic upd, input logic [5:0] uidx,
                       input logic bt, input logic pt);
    logic [5:0]  e_idx;
    logic [23:0] e;
    @(negedge clk);
    reset = 1'b0;
    PCF = pc;
    UpdateE = upd;
    UpdateIndexE = uidx;
    BranchTakenE = bt;
    PredictedTakenE = pt;
    #1;
    e_idx = pc[7:2] ^ hist_term();
    exp_q.push_back({e_idx, m_ctr[e_idx][1], upd & (bt ^ pt), m_cnt});
    e = exp_q.pop_front();
    chk("index", {26'd0, PredictIndexF}, {26'd0, e[23:18]});
    chk("predict", {31'd0, PredictTakenF}, {31'd0, e[17]});
    chk("mispredict", {31'd0, MispredictE}, {31'd0, e[16]});
    chk("count", {16'd0, MispredictCount}, {16'd0, e[15:0]});
    if (upd) begin
      if (bt && m_ctr[uidx] != 2'd3) m_ctr[uidx] = m_ctr[uidx] + 2'd1;
      if (!bt && m_ctr[uidx] != 2'd0) m_ctr[uidx] = m_ctr[uidx] - 2'd1;
      if ((bt ^ pt) && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      m_ghr = {m_ghr[4:0], bt};
    end
  endtask

  task automatic do_reset(input logic upd, input logic [5:0] uidx, input logic bt, input logic pt);
    @(negedge clk);
    reset = 1'b1;
    UpdateE = upd;
    UpdateIndexE = uidx;
    BranchTakenE = bt;
    PredictedTakenE = pt;
    #1;
    chk("misp_in_reset", {31'd0, MispredictE}, {31'd0, upd & (bt ^ pt)});
    model_clear();
  endtask

  task automatic sweep_all_zero();
    for (int i = 0; i < 64; i++) begin
      cycle({24'd0, 6'(i), 2'b00}, 1'b0, 6'd0, 1'b0, 1'b0);
      chk("sweep_pred0", {31'd0, PredictTakenF}, 32'd0);
    end
    chk("sweep_cnt0", {16'd0, MispredictCount}, 32'd0);
  endtask

  vec_t vecs[9];

  initial begin
    reset = 1'b1;
    PCF = 32'd0;
    UpdateE = 1'b0;
    UpdateIndexE = 6'd0;
    BranchTakenE = 1'b0;
    PredictedTakenE = 1'b0;
    model_clear();

    // counter walk at index 0x10 from PCF=0x40
    vecs[0] = '{32'h40, 1'b1, 6'h10, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{32'h40, 1'b1, 6'h10, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{32'h40, 1'b0, 6'h10, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h40, 1'b1, 6'h10, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{32'h40, 1'b1, 6'h10, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{32'h40, 1'b1, 6'h10, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{32'h40, 1'b0, 6'h10, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{32'h40, 1'b1, 6'h10, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{32'h40, 1'b0, 6'h10, 1'b0, 1'b0, 1'b0, 1'b0};

    // reset state, with a mispredicting update held during reset
    do_reset(1'b1, 6'd3, 1'b1, 1'b0);
    do_reset(1'b0, 6'd0, 1'b0, 1'b0);
    sweep_all_zero();

`ifndef GSHARE_EN
    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].pc, vecs[i].upd, vecs[i].uidx, vecs[i].bt, vecs[i].pt);
      chk("vec_pred", {31'd0, PredictTakenF}, {31'd0, vecs[i].exp_pred});
      chk("vec_misp", {31'd0, MispredictE}, {31'd0, vecs[i].exp_misp});
      chk("vec_index", {26'd0, PredictIndexF}, 32'h10);
    end
    cycle(32'h40, 1'b0, 6'd0, 1'b0, 1'b0);
    chk("vec_count", {16'd0, MispredictCount}, 32'd4);

    // same-cycle read of the entry being updated sees the old value
    cycle(32'h14, 1'b1, 6'd5, 1'b1, 1'b1);
    cycle(32'h14, 1'b1, 6'd5, 1'b1, 1'b1);
    chk("nobypass_old", {31'd0, PredictTakenF}, 32'd0);
    cycle(32'h14, 1'b0, 6'd5, 1'b0, 1'b0);
    chk("nobypass_new", {31'd0, PredictTakenF}, 32'd1);
`endif

    // two entries driven to 3, then reset lands on a further update
    for (int i = 0; i < 3; i++) begin
      cycle(32'd0, 1'b1, 6'd1, 1'b1, 1'b1);
      cycle(32'd0, 1'b1, 6'd2, 1'b1, 1'b1);
    end
    cycle(pc_for(6'd1), 1'b0, 6'd0, 1'b0, 1'b0);
    chk("sat_entry1", {31'd0, PredictTakenF}, 32'd1);
    do_reset(1'b1, 6'd7, 1'b1, 1'b0);
    sweep_all_zero();
    cycle(pc_for(6'd7), 1'b1, 6'd7, 1'b1, 1'b1);
    cycle(pc_for(6'd7), 1'b0, 6'd0, 1'b0, 1'b0);
    chk("reset_drops_update", {31'd0, PredictTakenF}, 32'd0);

`ifdef GSHARE_EN
    do_reset(1'b0, 6'd0, 1'b0, 1'b0);
    cycle(32'd0, 1'b1, 6'd0, 1'b1, 1'b1);
    cycle(32'd0, 1'b1, 6'd0, 1'b0, 1'b0);
    cycle(32'd0, 1'b1, 6'd0, 1'b1, 1'b1);
    cycle(32'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    chk("ghr_index", {26'd0, PredictIndexF}, 32'h05);
`endif

    // random traffic against the model
    do_reset(1'b0, 6'd0, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      int r_pc;
      int r_ix;
      r_pc = $urandom_range(0, 63);
      r_ix = $urandom_range(0, 15);
      cycle({24'd0, 6'(r_pc), 2'b00}, 1'($urandom_range(0, 1)), 6'(r_ix),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // mispredict counter saturation
    do_reset(1'b0, 6'd0, 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) begin
      cycle(32'h0, 1'b1, 6'd9, 1'b1, 1'b0);
    end
    chk("count_sat", {16'd0, MispredictCount}, 32'hFFFF);
    cycle(32'h0, 1'b1, 6'd9, 1'b1, 1'b0);
    cycle(32'h0, 1'b0, 6'd9, 1'b0, 1'b0);
    chk("count_hold", {16'd0, MispredictCount}, 32'hFFFF);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
